// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the memory stage: FSM states, datapath widths,
// and the word-alignment helper used for the data-memory address.
package memory_cycle_pkg;
  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/memory_cycle_mem_wb.sv
// MEM/WB pipeline register: a full load captures the M-stage fields, while a
// bubble only kills the register write so the W stage sees a no-op.
module mem_wb_reg
  import memory_cycle_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bubble,
  input  logic                 rdata_en,
  input  logic                 RegWriteM,
  input  logic                 ResultSrcM,
  input  logic [REGADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]      ALU_ResultM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [REGADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic [XLEN-1:0]      PCPlus4W
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
    end else if (load) begin
      // x0 is hardwired to zero, so a write to it is dropped here.
      RegWriteW   <= RegWriteM && (RD_M != '0);
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      PCPlus4W    <= PCPlus4M;
      if (rdata_en) ReadDataW <= mem_rdata;
    end else if (bubble) begin
      RegWriteW   <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: issues a held request on the data-memory bus for loads/stores,
// stalls upstream until the ack, and feeds the MEM/WB register.
module memory_cycle
  import memory_cycle_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ResultSrcM,
  input  logic [REGADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]      ALU_ResultM,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      PCPlus4M,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [REGADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [XLEN-1:0]      ResultW
);

  state_t state, next_state;
  logic   access;
  logic   wb_load, wb_bubble, wb_rdata_en;
  logic   start_access, finish_access;

  assign access = MemWriteM | ResultSrcM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    StallM        = 1'b0;
    wb_load       = 1'b0;
    wb_bubble     = 1'b0;
    wb_rdata_en   = 1'b0;
    start_access  = 1'b0;
    finish_access = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          StallM       = 1'b1;
          wb_bubble    = 1'b1;
          start_access = 1'b1;
          next_state   = BUSY;
        end else begin
          wb_load      = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          wb_load       = 1'b1;
          // A combined load+store encoding is a store: keep the old read data.
          wb_rdata_en   = ResultSrcM & ~MemWriteM;
          finish_access = 1'b1;
          next_state    = IDLE;
        end else begin
          StallM        = 1'b1;
          wb_bubble     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered so they stay frozen for the whole BUSY period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start_access) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWriteM;
      mem_addr  <= word_align(ALU_ResultM);
      mem_wdata <= WriteDataM;
    end else if (finish_access) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .load        (wb_load),
    .bubble      (wb_bubble),
    .rdata_en    (wb_rdata_en),
    .RegWriteM   (RegWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .ALU_ResultM (ALU_ResultM),
    .PCPlus4M    (PCPlus4M),
    .mem_rdata   (mem_rdata),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W)
  );

  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule
